// File: rtl/result_display.sv
// rtl/result_display.sv - ALU result to 4-digit multiplexed seven-segment display
// Sequential double-dabble conversion, sign/blanking/overflow formatting, digit scan.
module result_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        neg,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        busy,
    output logic        ovf
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] LOAD    = 2'd2;

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    logic [1:0]    state;
    logic [15:0]   snap_v;
    logic          snap_n;
    logic          dirty;
    logic [15:0]   shift;
    logic [19:0]   bcd;
    logic [19:0]   adj;
    logic [3:0]    step;
    logic [6:0]    p [4];
    logic [6:0]    fmt [4];
    logic          fmt_ovf;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'h40;
            4'd1:    digit_seg = 7'h79;
            4'd2:    digit_seg = 7'h24;
            4'd3:    digit_seg = 7'h30;
            4'd4:    digit_seg = 7'h19;
            4'd5:    digit_seg = 7'h12;
            4'd6:    digit_seg = 7'h02;
            4'd7:    digit_seg = 7'h78;
            4'd8:    digit_seg = 7'h00;
            4'd9:    digit_seg = 7'h10;
            default: digit_seg = SEG_BLANK;
        endcase
    endfunction

    assign busy = (state != IDLE);

    always_comb begin
        adj = '0;
        for (int i = 0; i < 5; i++) begin
            adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
    end

    // Leading-zero blanking; the minus sign sits just left of the top shown digit.
    always_comb begin
        fmt[0] = digit_seg(bcd[3:0]);
        fmt[1] = (bcd[15:4] != 12'd0) ? digit_seg(bcd[7:4])   : SEG_BLANK;
        fmt[2] = (bcd[15:8] != 8'd0)  ? digit_seg(bcd[11:8])  : SEG_BLANK;
        fmt[3] = (bcd[15:12] != 4'd0) ? digit_seg(bcd[15:12]) : SEG_BLANK;
        fmt_ovf = 1'b0;
        if (bcd[19:16] != 4'd0 || (snap_n && bcd[15:12] != 4'd0)) begin
            fmt[3]  = SEG_BLANK;
            fmt[2]  = SEG_E;
            fmt[1]  = SEG_R;
            fmt[0]  = SEG_R;
            fmt_ovf = 1'b1;
        end else if (snap_n && bcd[11:0] != 12'd0) begin
            if (bcd[11:8] != 4'd0)     fmt[3] = SEG_MINUS;
            else if (bcd[7:4] != 4'd0) fmt[2] = SEG_MINUS;
            else                       fmt[1] = SEG_MINUS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            snap_v <= '0;
            snap_n <= 1'b0;
            dirty  <= 1'b1;
            shift  <= '0;
            bcd    <= '0;
            step   <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < 4; i++) p[i] <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (dirty || {value, neg} != {snap_v, snap_n}) begin
                        snap_v <= value;
                        snap_n <= neg;
                        shift  <= value;
                        dirty  <= 1'b0;
                        bcd    <= '0;
                        step   <= '0;
                        state  <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd   <= {adj[18:0], shift[15]};
                    shift <= {shift[14:0], 1'b0};
                    step  <= step + 4'd1;
                    if (step == 4'd15) state <= LOAD;
                end
                LOAD: begin
                    for (int i = 0; i < 4; i++) p[i] <= fmt[i];
                    ovf   <= fmt_ovf;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            seg      <= SEG_BLANK;
            an       <= 4'b1110;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            seg <= p[idx];
            an  <= ~(4'b0001 << idx);
        end
    end
endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - randomized self-checking bench for result_display
// Displayed digits are gathered from the scanned seg/an outputs and compared to a decimal model.
module tb_result_display;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        neg = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;
    logic        ovf;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .value(value), .neg(neg),
        .seg(seg), .an(an), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {ovf, p3, p2, p1, p0} from the decimal value and sign.
    function automatic logic [28:0] model(input int v, input bit n);
        logic [6:0] p [4];
        int t, nd;
        if ((!n && v > 9999) || (n && v > 999))
            return {1'b1, 7'h7F, 7'h06, 7'h2F, 7'h2F};
        for (int i = 0; i < 4; i++) p[i] = 7'h7F;
        t = v;
        nd = 0;
        do begin
            p[nd] = segtab[t % 10];
            t = t / 10;
            nd++;
        end while (t != 0);
        if (n && v != 0) p[nd] = 7'h3F;
        return {1'b0, p[3], p[2], p[1], p[0]};
    endfunction

    // Waits for the current conversion to finish; returns the busy-high cycle count.
    task automatic run_conv(output int bcount);
        bit done = 0;
        bcount = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (busy) bcount++;
            else if (bcount > 0) done = 1;
        end
        if (!done) check("conv_timeout", 32'd0, 32'd1);
    endtask

    task automatic collect(output logic [27:0] disp);
        logic [6:0] o [4];
        int bad = 0;
        for (int i = 0; i < 4; i++) o[i] = 'x;
        repeat (4 * SCAN_DIV) begin
            @(negedge clk);
            case (an)
                4'b1110: o[0] = seg;
                4'b1101: o[1] = seg;
                4'b1011: o[2] = seg;
                4'b0111: o[3] = seg;
                default: bad++;
            endcase
        end
        check("an_valid", bad, 0);
        disp = {o[3], o[2], o[1], o[0]};
    endtask

    task automatic do_vec(input int v, input bit n);
        int bc;
        logic [27:0] disp;
        logic [28:0] exp;
        @(negedge clk);
        value = 16'(v);
        neg = n;
        run_conv(bc);
        check($sformatf("busy_len %0d/%0d", v, n), bc, 17);
        collect(disp);
        exp = model(v, n);
        check($sformatf("disp %0d/%0d", v, n), disp, exp[27:0]);
        check($sformatf("ovf %0d/%0d", v, n), ovf, exp[28]);
    endtask

    initial begin
        int bc;
        logic [3:0] ans [16];
        logic [27:0] disp;
        logic [28:0] exp;
        int bad;
        int pv, v;
        bit pn, n;

        value = 16'd1234;
        neg = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'b1110);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        run_conv(bc);
        check("first_busy_len", bc, 17);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ans[i] = an;
        end
        for (int i = 0; i < 12; i++)
            if (ans[i+4] !== {ans[i][2:0], ans[i][3]}) bad++;
        check("an_rotation", bad, 0);
        collect(disp);
        exp = model(1234, 0);
        check("disp_1234", disp, exp[27:0]);
        check("ovf_1234", ovf, 0);

        do_vec(42, 1);
        do_vec(0, 0);
        do_vec(0, 1);
        do_vec(10000, 0);
        do_vec(9999, 0);
        do_vec(1000, 1);
        do_vec(999, 1);
        do_vec(9, 1);
        do_vec(65535, 0);
        check("bcd_65535", dut.bcd, 20'h65535);

        // Input change in the middle of a conversion
        do_vec(3, 0);
        @(negedge clk);
        value = 16'd5;
        repeat (8) @(negedge clk);
        value = 16'd7;
        run_conv(bc);
        collect(disp);
        exp = model(5, 0);
        check("midchg_first", disp, exp[27:0]);
        run_conv(bc);
        collect(disp);
        exp = model(7, 0);
        check("midchg_second", disp, exp[27:0]);

        // Reset in the middle of a conversion
        @(negedge clk);
        value = 16'd321;
        neg = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_seg", seg, 7'h7F);
        check("midrst_an", an, 4'b1110);
        check("midrst_busy", busy, 0);
        check("midrst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        run_conv(bc);
        check("midrst_busy_len", bc, 17);
        collect(disp);
        exp = model(321, 1);
        check("midrst_disp", disp, exp[27:0]);

        pv = 321;
        pn = 1;
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 99);
                1: v = $urandom_range(0, 999);
                2: v = $urandom_range(0, 9999);
                default: v = $urandom_range(0, 65535);
            endcase
            n = 1'($urandom_range(0, 1));
            if (v == pv && n == pn) v = v ^ 1;
            do_vec(v, n);
            pv = v;
            pn = n;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/result_display.md
# result_display

Downstream stage of the calculator ALU. It takes the ALU's 16-bit unsigned magnitude and sign flag and converts them to decimal with a sequential double-dabble engine. It formats the result for a 4-digit multiplexed seven-segment display, with sign, leading-zero blanking and overflow indication, and scans the digits continuously.

## Interface
- SCAN_DIV, 50000: clock cycles each digit is held active; minimum 2.
- clk  in  1  system clock; every register is clocked on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- value  in  16  unsigned magnitude from the ALU (`out`).
- neg  in  1  sign from the ALU; 1 means the result is `-value`.
- seg  out  7  active-low segments, seg[0]=a … seg[6]=g; no decimal point.
- an  out  4  active-low digit enables; an[0] is the rightmost digit (p0).
- busy  out  1  high while a conversion is in progress (CONVERT or LOAD).
- ovf  out  1  high while the display shows the overflow pattern.

## Operation
- Snapshot registers: `snap_v` (16 bits), `snap_n` (1 bit), and a `dirty` flag. Reset sets `dirty`=1.
- FSM states: IDLE, CONVERT, LOAD.
  - IDLE: if `dirty` or {value,neg} differs from {snap_v,snap_n}: latch the inputs into the snapshot, clear `dirty`, clear the 20-bit BCD register and the 4-bit step counter, then go to CONVERT. Otherwise stay in IDLE.
  - CONVERT: one double-dabble step per cycle. Each BCD nibble ≥5 gets +3, then {bcd,shift} shifts left by 1, taking the MSB of the snapshot shift copy. The counter counts 0..15. After the step at count 15, go to LOAD.
  - LOAD: decode BCD digits d4..d0 into the four display registers p3..p0 and update `ovf`, then go to IDLE.
- Input changes during CONVERT or LOAD are ignored. They are detected by the IDLE compare on the following cycle.
- Formatting in LOAD, with N = the decimal value:
  - snap_n=0, N≤9999: digits right-aligned with leading zeros blanked. N=0 shows "0" at p0 only.
  - snap_n=1, 1≤N≤999: digits right-aligned with leading zeros blanked. '-' goes in the position immediately left of the most-significant shown digit; positions further left are blank.
  - snap_n=1, N=0: same as positive 0, with no sign.
  - snap_n=0 with N>9999, or snap_n=1 with N>999: show blank, E, r, r on p3..p0 and set ovf=1. Every non-overflow LOAD clears ovf.
- Segment codes, active-low, hex of {g..a}:
  - digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - symbols: '-'=3F, blank=7F, E=06, r=2F
- Scan logic:
  - A counter runs 0..SCAN_DIV-1. On wrap, digit index idx advances 0→1→2→3→0.
  - an = ~(4'b0001 << idx); seg = register p[idx]. Both are registered, and they change on the same edge.
- Reset values: FSM=IDLE, snapshot=0, dirty=1, all p registers blank, seg=7'h7F, an=4'b1110, idx=0, scan counter=0, busy=0, ovf=0.

## Timing
- Input change sampled at IDLE edge k: edges k+1..k+16 perform the 16 CONVERT steps. Edge k+17 is LOAD and writes p3..p0 and ovf.
- busy=1 from after edge k through edge k+17, i.e. 17 cycles. busy=0 after edge k+17.
- New digit patterns reach seg no later than the edge after k+17, for whichever digit is currently selected. Scan timing is independent of the conversion.
- First conversion after reset release starts at the first edge, caused by `dirty`.
- Back-to-back changes: at most one conversion is in flight. The final stable input is always displayed by 18 cycles after the input last changed plus one full conversion.
- Reset asserted mid-conversion: the conversion aborts immediately, the display blanks, and a fresh conversion runs after release.
- Display holds the previous result throughout a conversion; there is no intermediate flicker.

## Test plan
- Reset, then value=1234, neg=0, SCAN_DIV=4: busy high 17 cycles. After LOAD, p3..p0 = 79, 24, 30, 19. an cycles 1110→1101→1011→0111 every 4 cycles. ovf=0.
- value=42, neg=1 → p3..p0 = 7F, 3F, 19, 24; value=0, neg=0 → 7F, 7F, 7F, 40.
- value=10000, neg=0 → p3..p0 = 7F, 06, 2F, 2F, ovf=1. Then value=9999 → 10, 10, 10, 10, ovf=0. Then value=1000, neg=1 → overflow pattern, ovf=1.
- value=65535, neg=0 → overflow pattern. BCD register holds 6,5,5,3,5 at LOAD (checked via hierarchy).
- Change value from 5 to 7 at cycle 8 of CONVERT: the first LOAD shows 5. A second conversion starts on the following IDLE cycle and the display then shows 7.
- Assert rst mid-CONVERT for 1 cycle: seg=7F, an=1110, busy=0 immediately. After release, the current value is displayed within 18 cycles.
